pkt_fsm_multi: RTL

Parametrised multi-channel packet-framing tracker. Each channel runs an independent head/body/tail state machine over a valid/head/tail beat stream, counts beats per packet and flags framing violations. It sits beside packet sources as a protocol checker and statistics block, and generalises the single-channel head/tail framing FSM to N channels with length limits, error codes and a packet counter.

---
 rtl/pkt_fsm_multi.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pkt_fsm_multi.sv
// pkt_fsm_multi: multi-channel packet-framing tracker.
// Every channel runs its own IDLE/HEAD/BODY/ERR machine over a valid/head/tail
// beat stream. It counts beats per packet, reports the length of each legal
// packet and keeps a sticky record of the first framing error. A shared 16-bit
// counter accumulates the packets completed on all channels.
module pkt_fsm_multi #(
   parameter int CHANNELS = 4,
   parameter int LEN_W    = 8,
   parameter int MAX_LEN  = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       head,
   input  logic [CHANNELS-1:0]       tail,
   input  logic [CHANNELS-1:0]       valid,
   input  logic [CHANNELS-1:0]       err_clr,
   output logic [2*CHANNELS-1:0]     state,
   output logic [CHANNELS-1:0]       pkt_done,
   output logic [LEN_W*CHANNELS-1:0] pkt_len,
   output logic [CHANNELS-1:0]       err,
   output logic [2*CHANNELS-1:0]     err_code,
   output logic [15:0]               pkt_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HEAD = 2'd1,
      ST_BODY = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   localparam logic [LEN_W-1:0] MAX_LEN_C     = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_ZERO      = LEN_W'(0);
   localparam logic [LEN_W-1:0] LEN_ONE       = LEN_W'(1);
   localparam logic [1:0]       CODE_NONE     = 2'd0;
   localparam logic [1:0]       CODE_ORPHAN   = 2'd1;
   localparam logic [1:0]       CODE_NESTED   = 2'd2;
   localparam logic [1:0]       CODE_OVERFLOW = 2'd3;

   // Per-channel state and registered outputs
   state_t            state_q [CHANNELS];
   state_t            state_d [CHANNELS];
   logic [LEN_W-1:0]  cnt_q   [CHANNELS];
   logic [LEN_W-1:0]  cnt_d   [CHANNELS];
   logic [LEN_W-1:0]  len_q   [CHANNELS];
   logic [LEN_W-1:0]  len_d   [CHANNELS];
   logic [1:0]        code_q  [CHANNELS];
   logic [1:0]        code_d  [CHANNELS];
   logic [CHANNELS-1:0] done_q;
   logic [CHANNELS-1:0] done_d;
   logic [CHANNELS-1:0] err_q;
   logic [CHANNELS-1:0] err_d;
   logic [15:0]       count_q;
   logic [15:0]       count_d;

   // Error events raised by the framing machine this cycle
   logic [CHANNELS-1:0] new_err_s;
   logic [1:0]          new_code_s [CHANNELS];

   // Number of completions in one cycle, widened to the counter width
   function automatic logic [15:0] count_ones(input logic [CHANNELS-1:0] vec);
      logic [15:0] sum;
      sum = 16'd0;
      for (int k = 0; k < CHANNELS; k++) begin
         sum = sum + 16'(vec[k]);
      end
      return sum;
   endfunction

   // Framing machine: next state, beat counter, completion and error events
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         state_d[i]    = state_q[i];
         cnt_d[i]      = cnt_q[i];
         len_d[i]      = len_q[i];
         done_d[i]     = 1'b0;
         new_err_s[i]  = 1'b0;
         new_code_s[i] = CODE_NONE;
         if (valid[i]) begin
            case (state_q[i])
               ST_IDLE, ST_ERR: begin
                  if (head[i] && tail[i]) begin
                     // Single-beat packet
                     done_d[i]  = 1'b1;
                     len_d[i]   = LEN_ONE;
                     state_d[i] = ST_IDLE;
                     cnt_d[i]   = LEN_ZERO;
                  end else if (head[i]) begin
                     state_d[i] = ST_HEAD;
                     cnt_d[i]   = LEN_ONE;
                  end else if (state_q[i] == ST_IDLE) begin
                     // Beat with no open packet
                     state_d[i]    = ST_ERR;
                     cnt_d[i]      = LEN_ZERO;
                     new_err_s[i]  = 1'b1;
                     new_code_s[i] = CODE_ORPHAN;
                  end else begin
                     // Already in ERR: the stray beat is silently dropped
                     state_d[i] = ST_ERR;
                     cnt_d[i]   = LEN_ZERO;
                  end
               end
               ST_HEAD, ST_BODY: begin
                  if (head[i]) begin
                     // A head inside an open packet aborts it; it does not restart
                     state_d[i]    = ST_ERR;
                     cnt_d[i]      = LEN_ZERO;
                     new_err_s[i]  = 1'b1;
                     new_code_s[i] = CODE_NESTED;
                  end else if (cnt_q[i] == MAX_LEN_C) begin
                     // Any further beat would exceed the length limit
                     state_d[i]    = ST_ERR;
                     cnt_d[i]      = LEN_ZERO;
                     new_err_s[i]  = 1'b1;
                     new_code_s[i] = CODE_OVERFLOW;
                  end else if (tail[i]) begin
                     done_d[i]  = 1'b1;
                     len_d[i]   = cnt_q[i] + LEN_ONE;
                     state_d[i] = ST_IDLE;
                     cnt_d[i]   = LEN_ZERO;
                  end else begin
                     state_d[i] = ST_BODY;
                     cnt_d[i]   = cnt_q[i] + LEN_ONE;
                  end
               end
               default: begin
                  state_d[i] = ST_IDLE;
                  cnt_d[i]   = LEN_ZERO;
               end
            endcase
         end else begin
            // No beat: hold state and counter
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
         end
      end
   end

   // Sticky error flag and first-error code; a new error beats a clear
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         err_d[i]  = err_q[i];
         code_d[i] = code_q[i];
         if (new_err_s[i]) begin
            err_d[i] = 1'b1;
            if (!err_q[i] || err_clr[i]) begin
               code_d[i] = new_code_s[i];
            end else begin
               code_d[i] = code_q[i];
            end
         end else if (err_clr[i]) begin
            err_d[i]  = 1'b0;
            code_d[i] = CODE_NONE;
         end else begin
            err_d[i]  = err_q[i];
            code_d[i] = code_q[i];
         end
      end
   end

   // Shared packet counter advances by the completions of this edge
   always_comb begin
      count_d = count_q + count_ones(done_d);
   end

   // State and output registers with asynchronous active-low reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= ST_IDLE;
            cnt_q[i]   <= LEN_ZERO;
            len_q[i]   <= LEN_ZERO;
            code_q[i]  <= CODE_NONE;
         end
         done_q  <= '0;
         err_q   <= '0;
         count_q <= 16'd0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            len_q[i]   <= len_d[i];
            code_q[i]  <= code_d[i];
         end
         done_q  <= done_d;
         err_q   <= err_d;
         count_q <= count_d;
      end
   end

   // Pack per-channel registers onto the flat output buses
   for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
      assign state[2*g +: 2]         = state_q[g];
      assign pkt_len[LEN_W*g +: LEN_W] = len_q[g];
      assign err_code[2*g +: 2]      = code_q[g];
   end

   assign pkt_done  = done_q;
   assign err       = err_q;
   assign pkt_count = count_q;

endmodule
